// File: rtl/mesi_coherence_ctrl.sv
// mesi_coherence_ctrl: MESI coherence controller for NUM_CORES private
// direct-mapped caches (one word per line) sharing a single memory port.
// Optional feature macro: MESI_C2C_FWD_EN. When it is defined, a read miss on
// a line that a peer holds Modified takes its data from that peer instead of
// refilling from memory.
module mesi_coherence_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int LINES     = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req_valid,
    output logic [NUM_CORES-1:0]          req_ready,
    input  logic [NUM_CORES-1:0]          req_rw,
    input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   req_wdata,
    output logic [NUM_CORES-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_we,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [DATA_W-1:0]             mem_req_wdata,
    input  logic                          mem_resp_valid,
    input  logic [DATA_W-1:0]             mem_resp_rdata,
    output logic                          busy
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - 2;
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} line_state_e;
    typedef enum logic [2:0] {IDLE, LOOKUP, VICTIM_WB, SNOOP, OWNER_WB, FILL_REQ, FILL_WAIT, RESPOND} fsm_e;

    line_state_e       state_q [NUM_CORES][LINES];
    line_state_e       state_d [NUM_CORES][LINES];
    logic [TAG_W-1:0]  tag_q   [NUM_CORES][LINES];
    logic [TAG_W-1:0]  tag_d   [NUM_CORES][LINES];
    logic [DATA_W-1:0] data_q  [NUM_CORES][LINES];
    logic [DATA_W-1:0] data_d  [NUM_CORES][LINES];

    fsm_e              fsm_q, fsm_d;
    logic [CORE_W-1:0] rr_q, rr_d, core_q, core_d, owner_q, owner_d;
    logic              rw_q, rw_d, shared_q, shared_d;
    logic [ADDR_W-3:0] waddr_q, waddr_d;     // word address of the latched request
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    logic [IDX_W-1:0]     cur_idx;
    logic [TAG_W-1:0]     cur_tag;
    logic                 grant_found;
    logic [CORE_W-1:0]    grant_idx;
    logic [NUM_CORES-1:0] peer_hit;
    logic                 peer_m;
    logic [CORE_W-1:0]    owner_idx;
    logic                 own_hit;

    // Byte-offset bits of the request address carry no information.
    logic [2*NUM_CORES-1:0] unused_addr_lsbs;
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lsb
            assign unused_addr_lsbs[2*gi +: 2] = req_addr[gi*ADDR_W +: 2];
        end
    endgenerate

    function automatic logic [CORE_W-1:0] wrap_inc(input logic [CORE_W-1:0] v, input int k);
        int s;
        s = (int'(v) + k) % NUM_CORES;
        return CORE_W'(s);
    endfunction

    assign cur_idx = waddr_q[IDX_W-1:0];
    assign cur_tag = waddr_q[ADDR_W-3:IDX_W];
    assign own_hit = (state_q[core_q][cur_idx] != ST_I) && (tag_q[core_q][cur_idx] == cur_tag);

    // Round-robin pick: first valid core at or after the rotation pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!grant_found && req_valid[wrap_inc(rr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_inc(rr_q, i);
            end
        end
    end

    // Snoop of all peer caches at the requested index for a valid matching tag.
    always_comb begin
        peer_hit  = '0;
        peer_m    = 1'b0;
        owner_idx = '0;
        for (int p = 0; p < NUM_CORES; p++) begin
            if (CORE_W'(p) != core_q && state_q[p][cur_idx] != ST_I && tag_q[p][cur_idx] == cur_tag) begin
                peer_hit[p] = 1'b1;
                if (state_q[p][cur_idx] == ST_M) begin
                    peer_m    = 1'b1;
                    owner_idx = CORE_W'(p);
                end
            end
        end
    end

    // Transaction FSM: next state, cache array updates and all outputs.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        fsm_d    = fsm_q;
        rr_d     = rr_q;
        core_d   = core_q;
        owner_d  = owner_q;
        rw_d     = rw_q;
        shared_d = shared_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        req_ready     = '0;
        resp_valid    = '0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        busy          = (fsm_q != IDLE);
        case (fsm_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    core_d  = grant_idx;
                    rw_d    = req_rw[grant_idx];
                    waddr_d = req_addr[grant_idx*ADDR_W + 2 +: ADDR_W-2];
                    wdata_d = req_wdata[grant_idx*DATA_W +: DATA_W];
                    rr_d    = wrap_inc(grant_idx, 1);
                    fsm_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (own_hit && !rw_q) begin
                    rdata_d = data_q[core_q][cur_idx];
                    fsm_d   = RESPOND;
                end else if (own_hit && state_q[core_q][cur_idx] != ST_S) begin
                    // Exclusive ownership already held: write locally, no bus traffic.
                    state_d[core_q][cur_idx] = ST_M;
                    data_d[core_q][cur_idx]  = wdata_q;
                    rdata_d = '0;
                    fsm_d   = RESPOND;
                end else if (own_hit) begin
                    fsm_d = SNOOP;
                end else if (state_q[core_q][cur_idx] == ST_M) begin
                    fsm_d = VICTIM_WB;
                end else begin
                    state_d[core_q][cur_idx] = ST_I;
                    fsm_d = SNOOP;
                end
            end
            VICTIM_WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_q[core_q][cur_idx], cur_idx, 2'b00};
                mem_req_wdata = data_q[core_q][cur_idx];
                if (mem_req_ready) begin
                    state_d[core_q][cur_idx] = ST_I;
                    fsm_d = SNOOP;
                end
            end
            SNOOP: begin
                if (rw_q) begin
                    // Full-word write: peer copies are dropped without writeback.
                    for (int p = 0; p < NUM_CORES; p++)
                        if (peer_hit[p]) state_d[p][cur_idx] = ST_I;
                    state_d[core_q][cur_idx] = ST_M;
                    tag_d[core_q][cur_idx]   = cur_tag;
                    data_d[core_q][cur_idx]  = wdata_q;
                    rdata_d = '0;
                    fsm_d   = RESPOND;
                end else if (peer_m) begin
                    owner_d = owner_idx;
                    fsm_d   = OWNER_WB;
                end else begin
                    for (int p = 0; p < NUM_CORES; p++)
                        if (peer_hit[p]) state_d[p][cur_idx] = ST_S;
                    shared_d = |peer_hit;
                    fsm_d    = FILL_REQ;
                end
            end
            OWNER_WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {waddr_q, 2'b00};
                mem_req_wdata = data_q[owner_q][cur_idx];
                if (mem_req_ready) begin
                    state_d[owner_q][cur_idx] = ST_S;
`ifdef MESI_C2C_FWD_EN
                    state_d[core_q][cur_idx] = ST_S;
                    tag_d[core_q][cur_idx]   = cur_tag;
                    data_d[core_q][cur_idx]  = data_q[owner_q][cur_idx];
                    rdata_d = data_q[owner_q][cur_idx];
                    fsm_d   = RESPOND;
`else
                    shared_d = 1'b1;
                    fsm_d    = FILL_REQ;
`endif
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {waddr_q, 2'b00};
                if (mem_req_ready) fsm_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    state_d[core_q][cur_idx] = shared_q ? ST_S : ST_E;
                    tag_d[core_q][cur_idx]   = cur_tag;
                    data_d[core_q][cur_idx]  = mem_resp_rdata;
                    rdata_d = mem_resp_rdata;
                    fsm_d   = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid[core_q] = 1'b1;
                resp_rdata = rdata_q;
                fsm_d      = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight and empties every cache.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int l = 0; l < LINES; l++) begin
                    state_q[c][l] <= ST_I;
                    tag_q[c][l]   <= '0;
                    data_q[c][l]  <= '0;
                end
            end
            fsm_q    <= IDLE;
            rr_q     <= '0;
            core_q   <= '0;
            owner_q  <= '0;
            rw_q     <= 1'b0;
            shared_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            fsm_q    <= fsm_d;
            rr_q     <= rr_d;
            core_q   <= core_d;
            owner_q  <= owner_d;
            rw_q     <= rw_d;
            shared_q <= shared_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mesi_coherence_ctrl.sv
// Directed testbench for mesi_coherence_ctrl (NUM_CORES=4, LINES=16).
// Expectations for the forwarding case follow MESI_C2C_FWD_EN.
`timescale 1ns/1ps
module tb_mesi_coherence_ctrl;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] req_valid, req_ready, req_rw, resp_valid;
    logic [NC*32-1:0] req_addr, req_wdata;
    logic [31:0]   resp_rdata;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]   mem_req_addr, mem_req_wdata;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mesi_coherence_ctrl #(.NUM_CORES(NC), .LINES(16), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_model [logic [31:0]];
    logic        log_we   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        mem_hold = 1'b0;

    initial begin
        int          wait_cnt;
        int          rsp_cnt;
        logic [31:0] rsp_addr;
        bit          acc_pend, stall_pend;
        logic        c_we;
        logic [31:0] c_addr, c_data;
        wait_cnt = 0; rsp_cnt = 0; rsp_addr = '0;
        acc_pend = 0; stall_pend = 0; c_we = 0; c_addr = '0; c_data = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_model[32'h40] = 32'hA5A5_0001;
        forever begin
            @(negedge clk);
            if (acc_pend) begin
                log_we.push_back(c_we);
                log_addr.push_back(c_addr);
                log_data.push_back(c_data);
                $display("mem %s addr=0x%0h data=0x%0h", c_we ? "wr" : "rd", c_addr, c_data);
                if (c_we) mem_model[c_addr] = c_data;
                else begin rsp_cnt = 2; rsp_addr = c_addr; end
                acc_pend = 0;
                wait_cnt = 0;
            end
            mem_resp_valid = 1'b0;
            if (rsp_cnt == 1 && !mem_hold) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = mem_model.exists(rsp_addr) ? mem_model[rsp_addr] : 32'h0;
                rsp_cnt = 0;
            end else if (rsp_cnt > 1) begin
                rsp_cnt--;
            end
            if (stall_pend && mem_req_valid) begin
                check_eq("mem_stable", {mem_req_we, mem_req_addr, mem_req_wdata}, {c_we, c_addr, c_data});
            end
            stall_pend = 0;
            if (mem_req_valid && !reset) begin
                mem_req_ready = (wait_cnt >= 1);
                wait_cnt++;
                c_we = mem_req_we; c_addr = mem_req_addr; c_data = mem_req_wdata;
                if (mem_req_ready) acc_pend = 1;
                else stall_pend = 1;
            end else begin
                mem_req_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic int count_valid_lines();
        int n = 0;
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < 16; l++)
                if (dut.state_q[c][l] != 0) n++;
        return n;
    endfunction

    task automatic check_log(input string tag, input int pos, input logic we,
                             input logic [31:0] addr, input logic [31:0] data);
        if (pos < log_we.size()) begin
            check_eq({tag, "_we"}, log_we[pos], we);
            check_eq({tag, "_addr"}, log_addr[pos], addr);
            if (we) check_eq({tag, "_data"}, log_data[pos], data);
        end else begin
            check_eq({tag, "_present"}, log_we.size(), pos + 1);
        end
    endtask

    task automatic do_req(input int core, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        req_rw[core] = rw;
        req_addr[core*32 +: 32]  = addr;
        req_wdata[core*32 +: 32] = wdata;
        req_valid[core] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (req_ready[core]) break;
            @(negedge clk);
        end
        check_eq({tag, "_grant"}, req_ready, 64'(1) << core);
        @(posedge clk);
        #1 req_valid[core] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            lat = n;
            if (resp_valid != 0) break;
        end
        check_eq({tag, "_resp"}, resp_valid, 64'(1) << core);
        check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
        if (exp_lat > 0) check_eq({tag, "_lat"}, lat, exp_lat);
        @(negedge clk);
        check_eq({tag, "_pulse"}, resp_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        logic acc_resp, acc_busy;
        reset = 1'b1;
        req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_resp", {resp_valid, resp_rdata}, 0);
        check_eq("rst_memreq", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, 0);
        check_eq("rst_lines", count_valid_lines(), 0);
        reset = 1'b0;

        // Cold read miss, no sharers -> Exclusive.
        base = log_we.size();
        do_req(0, 1'b0, 32'h40, 32'h0, 32'hA5A5_0001, 0, "c0_rd40");
        check_eq("c0_rd40_nmem", log_we.size() - base, 1);
        check_log("c0_rd40_mem", base, 1'b0, 32'h40, 32'h0);
        check_eq("c0_rd40_st0", dut.state_q[0][0], 2);

        // Second reader: clean peer -> both Shared, refill from memory.
        base = log_we.size();
        do_req(1, 1'b0, 32'h40, 32'h0, 32'hA5A5_0001, 0, "c1_rd40");
        check_eq("c1_rd40_nmem", log_we.size() - base, 1);
        check_log("c1_rd40_mem", base, 1'b0, 32'h40, 32'h0);
        check_eq("c1_rd40_st0", dut.state_q[0][0], 1);
        check_eq("c1_rd40_st1", dut.state_q[1][0], 1);

        // Write hit on Shared: invalidate peer, upgrade to Modified.
        base = log_we.size();
        do_req(1, 1'b1, 32'h40, 32'h1234, 32'h0, 3, "c1_wr40");
        check_eq("c1_wr40_nmem", log_we.size() - base, 0);
        check_eq("c1_wr40_st0", dut.state_q[0][0], 0);
        check_eq("c1_wr40_st1", dut.state_q[1][0], 3);

        // Read miss on a peer-Modified line: owner writeback.
        base = log_we.size();
        do_req(2, 1'b0, 32'h40, 32'h0, 32'h1234, 0, "c2_rd40");
        check_log("c2_rd40_wb", base, 1'b1, 32'h40, 32'h1234);
`ifdef MESI_C2C_FWD_EN
        check_eq("c2_rd40_nmem", log_we.size() - base, 1);
`else
        check_eq("c2_rd40_nmem", log_we.size() - base, 2);
        check_log("c2_rd40_fill", base + 1, 1'b0, 32'h40, 32'h0);
`endif
        check_eq("c2_rd40_st1", dut.state_q[1][0], 1);
        check_eq("c2_rd40_st2", dut.state_q[2][0], 1);

        // Read hit: two-cycle latency, no memory traffic.
        base = log_we.size();
        do_req(2, 1'b0, 32'h40, 32'h0, 32'h1234, 2, "c2_rdhit");
        check_eq("c2_rdhit_nmem", log_we.size() - base, 0);

        // Write miss evicting a Shared line silently.
        base = log_we.size();
        do_req(1, 1'b1, 32'h440, 32'h55, 32'h0, 3, "c1_wr440");
        check_eq("c1_wr440_nmem", log_we.size() - base, 0);
        check_eq("c1_wr440_st1", dut.state_q[1][0], 3);

        // Write miss evicting a Modified line: victim writeback, peer invalidated.
        base = log_we.size();
        do_req(1, 1'b1, 32'h40, 32'h66, 32'h0, 0, "c1_wr40b");
        check_eq("c1_wr40b_nmem", log_we.size() - base, 1);
        check_log("c1_wr40b_wb", base, 1'b1, 32'h440, 32'h55);
        check_eq("c1_wr40b_st2", dut.state_q[2][0], 0);
        check_eq("c1_wr40b_st1", dut.state_q[1][0], 3);
        check_eq("c1_wr40b_data", dut.data_q[1][0], 32'h66);

        // Write hit on Modified: two-cycle latency, no traffic.
        base = log_we.size();
        do_req(1, 1'b1, 32'h40, 32'h77, 32'h0, 2, "c1_wrhit");
        check_eq("c1_wrhit_nmem", log_we.size() - base, 0);
        check_eq("c1_wrhit_data", dut.data_q[1][0], 32'h77);

        // All four cores request together with the pointer at 2.
        check_eq("rr_ptr", dut.rr_q, 2);
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            req_rw[c] = 1'b1;
            req_addr[c*32 +: 32]  = 32'h200 + 32'(4 * (c + 1));
            req_wdata[c*32 +: 32] = 32'(c);
        end
        req_valid = '1;
        for (int k = 0; k < NC; k++) begin
            int expc;
            expc = (2 + k) % NC;
            for (int n = 0; n < 50; n++) begin
                #1;
                if (req_ready != 0) break;
                @(negedge clk);
            end
            check_eq($sformatf("rr_grant%0d", k), req_ready, 64'(1) << expc);
            @(posedge clk);
            #1 req_valid[expc] = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (resp_valid != 0) break;
            end
            check_eq($sformatf("rr_resp%0d", k), resp_valid, 64'(1) << expc);
        end
        req_valid = '0;

        // Reset while waiting for fill data.
        mem_hold = 1'b1;
        base = log_we.size();
        @(negedge clk);
        req_rw[0] = 1'b0;
        req_addr[0 +: 32] = 32'h80;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (req_ready[0]) break;
            @(negedge clk);
        end
        check_eq("rstfw_grant", req_ready, 1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (log_we.size() > base) break;
        end
        check_log("rstfw_fill", base, 1'b0, 32'h80, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("rstfw_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check_eq("rstfw_busy", busy, 0);
        check_eq("rstfw_memreq", mem_req_valid, 0);
        check_eq("rstfw_lines", count_valid_lines(), 0);
        check_eq("rstfw_rr", dut.rr_q, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_hold = 1'b0;
        acc_resp = 1'b0;
        acc_busy = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            acc_resp = acc_resp | (|resp_valid);
            acc_busy = acc_busy | busy;
        end
        check_eq("rstfw_noresp", acc_resp, 0);
        check_eq("rstfw_idle", acc_busy, 0);

        // Post-reset read: memory holds the owner writeback value.
        base = log_we.size();
        do_req(3, 1'b0, 32'h40, 32'h0, 32'h1234, 0, "c3_rd40");
        check_eq("c3_rd40_nmem", log_we.size() - base, 1);
        check_eq("c3_rd40_st3", dut.state_q[3][0], 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
